// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, reply bytes,
// sequencer states and the saturating error-count helper.
package uart_cmd_pkg;

   localparam logic [7:0] OP_TURN_ON   = 8'h6E;
   localparam logic [7:0] OP_TURN_OFF  = 8'h55;
   localparam logic [7:0] OP_TOGGLE    = 8'hC3;
   localparam logic [7:0] OP_SET_DUTY  = 8'h3D;
   localparam logic [7:0] OP_STATUS    = 8'h5A;

   localparam logic [7:0] ACK_DEFAULT  = 8'h6B;
   localparam logic [7:0] NACK_DEFAULT = 8'hA5;

   localparam logic [6:0] ERR_MAX      = 7'h7F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ARG,
      S_TX_START,
      S_TX_WAIT_HI,
      S_TX_WAIT_LO
   } state_t;

   // Error counter increments but sticks at its maximum instead of wrapping.
   function automatic logic [6:0] err_sat_inc(input logic [6:0] v);
      return (v == ERR_MAX) ? v : v + 7'd1;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes one/two-byte commands, updates the SPWM
// enable/duty registers and answers every command with one reply byte.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 120000,
   parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
   parameter logic [7:0]  NACK_BYTE      = NACK_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] data_received,
   input  logic       parity_error,
   input  logic       tx_busy,
   output logic       start_tx,
   output logic [7:0] data_to_tx,
   output logic       pwm_enable,
   output logic [7:0] duty,
   output logic       cfg_update,
   output logic [6:0] err_cnt
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Last counter value still inside the argument window; a byte arriving in
   // that same cycle is still accepted.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        r_state, w_state_nx;
   logic          r_start_tx, w_start_nx;
   logic [7:0]    r_data_to_tx, w_data_nx;
   logic          r_pwm_enable, w_en_nx;
   logic [7:0]    r_duty, w_duty_nx;
   logic          r_cfg_update, w_cfg_nx;
   logic [6:0]    r_err_cnt, w_err_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic [1:0]    r_hi_cnt, w_hi_nx;

   assign start_tx   = r_start_tx;
   assign data_to_tx = r_data_to_tx;
   assign pwm_enable = r_pwm_enable;
   assign duty       = r_duty;
   assign cfg_update = r_cfg_update;
   assign err_cnt    = r_err_cnt;

   // State and register update; reset abandons any reply in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_start_tx   <= 1'b0;
         r_data_to_tx <= '0;
         r_pwm_enable <= 1'b0;
         r_duty       <= '0;
         r_cfg_update <= 1'b0;
         r_err_cnt    <= '0;
         r_cnt        <= '0;
         r_hi_cnt     <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_start_tx   <= w_start_nx;
         r_data_to_tx <= w_data_nx;
         r_pwm_enable <= w_en_nx;
         r_duty       <= w_duty_nx;
         r_cfg_update <= w_cfg_nx;
         r_err_cnt    <= w_err_nx;
         r_cnt        <= w_cnt_nx;
         r_hi_cnt     <= w_hi_nx;
      end
   end

   // Command decode, argument timeout and reply handshake with uart_tx.
   always_comb begin
      w_state_nx = r_state;
      w_start_nx = 1'b0;
      w_data_nx  = r_data_to_tx;
      w_en_nx    = r_pwm_enable;
      w_duty_nx  = r_duty;
      w_cfg_nx   = 1'b0;
      w_err_nx   = r_err_cnt;
      w_cnt_nx   = r_cnt;
      w_hi_nx    = r_hi_cnt;

      case (r_state)
         S_IDLE: begin
            if (rx_done) begin
               w_state_nx = S_TX_START;
               if (parity_error) begin
                  w_data_nx = NACK_BYTE;
                  w_err_nx  = err_sat_inc(r_err_cnt);
               end else begin
                  case (data_received)
                     OP_TURN_ON: begin
                        w_en_nx   = 1'b1;
                        w_cfg_nx  = 1'b1;
                        w_data_nx = ACK_BYTE;
                     end
                     OP_TURN_OFF: begin
                        w_en_nx   = 1'b0;
                        w_cfg_nx  = 1'b1;
                        w_data_nx = ACK_BYTE;
                     end
                     OP_TOGGLE: begin
                        w_en_nx   = ~r_pwm_enable;
                        w_cfg_nx  = 1'b1;
                        w_data_nx = ACK_BYTE;
                     end
                     OP_STATUS: begin
                        w_data_nx = {r_pwm_enable, r_err_cnt};
                     end
                     OP_SET_DUTY: begin
                        w_state_nx = S_WAIT_ARG;
                        w_cnt_nx   = '0;
                     end
                     default: begin
                        w_data_nx = NACK_BYTE;
                        w_err_nx  = err_sat_inc(r_err_cnt);
                     end
                  endcase
               end
            end
         end

         S_WAIT_ARG: begin
            w_cnt_nx = r_cnt + CW'(1);
            if (rx_done) begin
               w_state_nx = S_TX_START;
               if (parity_error) begin
                  w_data_nx = NACK_BYTE;
                  w_err_nx  = err_sat_inc(r_err_cnt);
               end else begin
                  w_duty_nx = data_received;
                  w_cfg_nx  = 1'b1;
                  w_data_nx = ACK_BYTE;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_state_nx = S_TX_START;
               w_data_nx  = NACK_BYTE;
               w_err_nx   = err_sat_inc(r_err_cnt);
            end
         end

         S_TX_START: begin
            if (!tx_busy) begin
               w_start_nx = 1'b1;
               w_hi_nx    = '0;
               w_state_nx = S_TX_WAIT_HI;
            end
         end

         // Transmitter that never reports busy is assumed to have sent the byte.
         S_TX_WAIT_HI: begin
            if (tx_busy) begin
               w_state_nx = S_TX_WAIT_LO;
            end else if (r_hi_cnt == 2'd3) begin
               w_state_nx = S_IDLE;
            end else begin
               w_hi_nx = r_hi_cnt + 2'd1;
            end
         end

         S_TX_WAIT_LO: begin
            if (!tx_busy) begin
               w_state_nx = S_IDLE;
            end
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

endmodule
